// File: rtl/axi_wr_beat_ctrl.sv
// axi_wr_beat_ctrl: write-data stage feeding the AXI W channel.
// Buffers 64-byte decompressed beats in a registered FIFO, marks wlast on
// every BURST_BEATS boundary and on the file's final beat, trims the final
// beat's strobes, and counts B responses to signal file completion.
// Optional build macro: AXI_WR_BRESP_CHECK_EN enables the sticky err flag.
`timescale 1ns/1ps
module axi_wr_beat_ctrl #(
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned BURST_BEATS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [31:0]         decompression_length,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  output logic                wlast,
  input  logic                bvalid,
  input  logic                bready,
  input  logic [1:0]          bresp,
  output logic                done,
  output logic                busy,
  output logic                err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned BB_W   = $clog2(BURST_BEATS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_B, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [26:0]   total_q, beats_in_q, beats_out_q;
  logic [5:0]    tail_q;
  logic [20:0]   exp_bursts_q, b_cnt_q, b_cnt_nxt;
  logic [BB_W-1:0] burst_beat_q;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;

  logic [26:0] len_beats;
  logic [20:0] len_bursts;
  logic        start_acc, fifo_full, fifo_empty, push, pop;
  logic        w_hs, b_hs, b_cnt_inc, last_of_file;

  // File geometry derived from the requested byte length
  assign len_beats  = {1'b0, decompression_length[31:6]} + {26'd0, |decompression_length[5:0]};
  assign len_bursts = 21'((len_beats >> BB_W) + {26'd0, |len_beats[BB_W-1:0]});

  assign start_acc  = start & (state_q == S_IDLE);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign in_ready   = (state_q == S_RUN) & ~fifo_full & (beats_in_q < total_q);
  assign push       = in_valid & in_ready;
  assign wvalid     = (state_q == S_RUN) & ~fifo_empty;
  assign w_hs       = wvalid & wready;
  assign pop        = w_hs;
  assign wdata      = mem[rd_ptr_q];

  assign last_of_file = (beats_out_q == total_q - 27'd1);
  assign wlast        = wvalid & ((burst_beat_q == BB_W'(BURST_BEATS - 1)) | last_of_file);

  // Responses past the expected count are not counted, so the compare below stays exact
  assign b_hs      = bvalid & bready & ((state_q == S_RUN) | (state_q == S_WAIT_B));
  assign b_cnt_inc = b_hs & (b_cnt_q != exp_bursts_q);
  assign b_cnt_nxt = b_cnt_q + {20'd0, b_cnt_inc};

  assign done = (state_q == S_DONE);
  assign busy = (state_q != S_IDLE);

  // Final-beat strobe trimming; strobes are zero while no beat is presented
  always_comb begin
    wstrb = '0;
    if (wvalid) begin
      wstrb = '1;
      if (last_of_file && (tail_q != '0)) begin
        for (int unsigned i = 0; i < STRB_W; i++) begin
          wstrb[i] = (i < 32'(tail_q));
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; WAIT_B looks at the post-increment count so done
  // follows the final B handshake by one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (len_beats == '0) ? S_DONE : S_RUN;
      S_RUN:    if (w_hs && last_of_file) state_d = S_WAIT_B;
      S_WAIT_B: if (b_cnt_nxt == exp_bursts_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // File counters: latched on accepted start, advanced by handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q      <= '0;
      tail_q       <= '0;
      exp_bursts_q <= '0;
      beats_in_q   <= '0;
      beats_out_q  <= '0;
      burst_beat_q <= '0;
      b_cnt_q      <= '0;
    end else if (start_acc) begin
      total_q      <= len_beats;
      tail_q       <= decompression_length[5:0];
      exp_bursts_q <= len_bursts;
      beats_in_q   <= '0;
      beats_out_q  <= '0;
      burst_beat_q <= '0;
      b_cnt_q      <= '0;
    end else begin
      if (push) beats_in_q <= beats_in_q + 27'd1;
      if (w_hs) begin
        beats_out_q  <= beats_out_q + 27'd1;
        burst_beat_q <= wlast ? '0 : burst_beat_q + BB_W'(1);
      end
      b_cnt_q <= b_cnt_nxt;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

`ifdef AXI_WR_BRESP_CHECK_EN
  logic err_q;

  // Sticky error on a bad response or on a response beyond the expected count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (start_acc) err_q <= 1'b0;
    else if (b_hs && ((bresp != 2'b00) || (b_cnt_q == exp_bursts_q))) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^bresp;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_beat_ctrl.sv
// Randomized self-checking bench for axi_wr_beat_ctrl with a queue-based
// reference model of the file's beat stream and completion timing.
`timescale 1ns/1ps
module tb_axi_wr_beat_ctrl;

  localparam int unsigned DATA_W = 512;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned BB     = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       decompression_length = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready = 1'b0;
  logic              wlast;
  logic              bvalid = 1'b0;
  logic              bready = 1'b0;
  logic [1:0]        bresp = 2'b00;
  logic              done, busy, err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  axi_wr_beat_ctrl #(
    .DATA_W(DATA_W),
    .FIFO_DEPTH(64),
    .BURST_BEATS(BB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .decompression_length(decompression_length),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .done(done), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_beat();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Reference model state (written only by the monitor)
  logic [DATA_W-1:0] q[$];
  int unsigned m_total = 0, m_tail = 0, m_expb = 0;
  int unsigned m_acc = 0, m_out = 0, m_b = 0, m_wl = 0;
  bit          m_err = 0, exp_busy = 0, done_due = 0;
  int unsigned done_cnt = 0;
  bit          prev_stall = 0;
  logic [DATA_W-1:0] prev_wdata;
  logic [STRB_W-1:0] prev_wstrb;
  logic              prev_wlast;

  always @(negedge clk) begin
    logic [DATA_W-1:0] exp_data;
    logic [STRB_W-1:0] exp_strb, one;
    bit cur_busy, cur_due, is_final, exp_last;
    if (!rst_n) begin
      chk("rst_wvalid", wvalid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_wlast", wlast, 1'b0);
      chk("rst_wstrb", wstrb, '0);
      chk("rst_err", err, 1'b0);
      q.delete();
      exp_busy = 0; done_due = 0; prev_stall = 0;
    end else begin
      cur_busy = exp_busy;
      cur_due  = done_due;
      done_due = 0;
      chk("done", done, cur_due);
      chk("busy", busy, cur_busy);
      if (cur_due) begin
        chk("err", err, m_err);
        chk("accepted", m_acc, m_total);
        chk("sent", m_out, m_total);
        exp_busy = 0;
        done_cnt++;
      end
      chk("wvalid", wvalid, q.size() != 0);
      if (cur_busy && m_acc == m_total) chk("in_ready_lim", in_ready, 1'b0);
      if (prev_stall) begin
        chk("stall_wvalid", wvalid, 1'b1);
        chk("stall_wdata", wdata, prev_wdata);
        chk("stall_wlast", wlast, prev_wlast);
        chk("stall_wstrb", wstrb, prev_wstrb);
      end
      if (wvalid && wready && q.size() != 0) begin
        exp_data = q.pop_front();
        is_final = (m_out == m_total - 1);
        exp_last = ((m_out + 1) % BB == 0) || is_final;
        exp_strb = '1;
        one = 1;
        if (is_final && m_tail != 0) exp_strb = (one << m_tail) - one;
        chk("wdata", wdata, exp_data);
        chk("wlast", wlast, exp_last);
        chk("wstrb", wstrb, exp_strb);
        m_out++;
        if (exp_last) m_wl++;
      end
      prev_stall = wvalid && !wready;
      prev_wdata = wdata;
      prev_wlast = wlast;
      prev_wstrb = wstrb;
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        m_acc++;
      end
      if (bvalid && bready && cur_busy && m_b < m_expb) begin
        m_b++;
`ifdef AXI_WR_BRESP_CHECK_EN
        if (bresp != 2'b00) m_err = 1;
`endif
        if (m_b == m_expb) done_due = 1;
      end
      if (start && !cur_busy) begin
        m_total = decompression_length[31:6] + ((decompression_length[5:0] != 0) ? 1 : 0);
        m_tail  = decompression_length[5:0];
        m_expb  = (m_total + BB - 1) / BB;
        m_acc = 0; m_out = 0; m_b = 0; m_wl = 0; m_err = 0;
        exp_busy = 1;
        if (m_total == 0) done_due = 1;
      end
    end
  end

  // bmode: 0 = OKAY responses, 1 = SLVERR responses, 2 = random mix
  task automatic run_file(input logic [31:0] len, input int unsigned iv_pct,
                          input int unsigned wr_pct, input int unsigned abort_at,
                          input int unsigned bmode);
    int unsigned b_issued = 0;
    int unsigned snap;
    bit fin = 0;
    @(posedge clk); #1;
    snap = done_cnt;
    start = 1'b1;
    decompression_length = len;
    @(posedge clk); #1;
    start = 1'b0;
    decompression_length = $urandom();
    for (int c = 0; c < 20000 && !fin; c++) begin
      if (done_cnt != snap) begin
        fin = 1;
      end else if (abort_at != 0 && c == abort_at) begin
        rst_n = 1'b0;
        in_valid = 1'b0; wready = 1'b0; bvalid = 1'b0; bready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fin = 1;
      end else begin
        if (bvalid && bready) bvalid = 1'b0;
        if (!bvalid && b_issued < m_wl) begin
          bvalid = 1'b1;
          bresp = (bmode == 1) ? 2'b10 :
                  (bmode == 2 && $urandom_range(99) < 20) ? 2'b10 : 2'b00;
          b_issued++;
        end
        bready   = ($urandom_range(99) < 70);
        in_valid = ($urandom_range(99) < iv_pct);
        in_data  = rnd_beat();
        wready   = ($urandom_range(99) < wr_pct);
        if (c == 7 && exp_busy) begin
          start = 1'b1;
          decompression_length = $urandom();
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    if (abort_at == 0) chk("timeout", done_cnt != snap, 1'b1);
    start = 1'b0; in_valid = 1'b0; wready = 1'b0; bvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [31:0] len;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_file(32'd4096, 100, 100, 0, 0);
    run_file(32'd8200, 100, 100, 0, 0);
    run_file(32'd0,    100, 100, 0, 0);
    run_file(32'd256,  60,  50,  0, 0);
    run_file(32'd4096, 100, 100, 20, 0);
    run_file(32'd64,   100, 100, 0, 0);
    run_file(32'd64,   100, 100, 0, 1);
    run_file(32'd130,  80,  70,  0, 0);

    for (int f = 0; f < 8; f++) begin
      case ($urandom_range(3))
        0: len = $urandom_range(20000);
        1: len = 4096 * $urandom_range(1, 4);
        2: len = 64 * $urandom_range(1, 200);
        default: len = $urandom_range(1, 63);
      endcase
      run_file(len, $urandom_range(30, 100), $urandom_range(30, 100), 0, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
